// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and constants for the hex/decimal 7-segment display controller.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_UPDATE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit 0 = a ... bit 6 = g; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  // Decimal digits needed for 2**w-1: floor(w*log10(2)) + 1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Load handshake bundle: the producer offers a value and a rendering mode.
interface hex_load_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              dec;

  modport master (output valid, output data, output dec, input  ready);
  modport slave  (input  valid, input  data, input  dec, output ready);
endinterface

// File: rtl/hex_display_ctrl_seg7_lut.sv
// One digit: 4-bit code plus blank flag to active-low 7-segment pattern.
module seg7_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_TABLE[code];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment controller: hex or serial double-dabble decimal rendering,
// leading-zero blanking, overflow flag and per-digit blinking.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int NUM_DIGITS    = 6,
  parameter int BLANK_LEADING = 1,
  parameter int BLINK_DIV     = 25000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    load_dec,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    overflow
);

  localparam int HEX_N  = (DATA_W + 3) / 4;
  localparam int BCD_N  = bcd_digits(DATA_W);
  localparam int WORK_D = max_int(max_int(HEX_N, BCD_N), NUM_DIGITS);
  localparam int CW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                state_q, state_d;
  logic                  accept;
  logic                  dec_q;
  logic [DATA_W-1:0]     bin_q;
  logic [4*BCD_N-1:0]    bcd_q, bcd_adj, bcd_step;
  logic [CW-1:0]         cnt_q;
  logic [4*WORK_D-1:0]   src;
  logic [WORK_D-1:0]     lead_zero;
  logic                  zero_run;
  logic                  ovf_d;
  logic [3:0]            code_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [BW-1:0]         blink_cnt_q;
  logic                  blink_phase;

  assign accept = load_valid & load_ready;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_d = load_dec ? ST_CONV : ST_UPDATE;
      end
      ST_CONV:   if (cnt_q == CW'(DATA_W - 1)) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: conversion registers are always loaded on acceptance before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dec_q <= load_dec;
      bin_q <= load_data;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_CONV) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < BCD_N; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[4*BCD_N-2:0], bin_q[DATA_W-1]};
  end

  // Digits above NUM_DIGITS feed only the overflow flag and the blanking scan.
  always_comb begin
    src = '0;
    if (dec_q) src[4*BCD_N-1:0] = bcd_q;
    else       src[DATA_W-1:0]  = bin_q;
    lead_zero = '0;
    zero_run  = 1'b1;
    ovf_d     = 1'b0;
    for (int i = WORK_D - 1; i >= 0; i--) begin
      zero_run     = zero_run & (src[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
      if (i >= NUM_DIGITS && src[4*i +: 4] != 4'd0) ovf_d = 1'b1;
    end
    blank_d = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank_d[i] = (BLANK_LEADING != 0) && lead_zero[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blank_q  <= '1;
      overflow <= 1'b0;
    end else if (state_q == ST_UPDATE) begin
      blank_q  <= blank_d;
      overflow <= ovf_d;
    end
  end

  // NOTE: the code array is not reset; after reset every digit is hidden by its blank flag.
  always_ff @(posedge clk) begin
    if (state_q == ST_UPDATE) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= src[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_lut u_lut (
      .code  (code_q[i]),
      .blank (blank_q[i] | (~blink_phase & blink_mask[i])),
      .seg   (HEX[7*i +: 7])
    );
  end

endmodule
